// File: rtl/clkwiz_pkg.sv
// Shared types and constants for the clock-wizard bring-up / clock-switch sequencer.
package clkwiz_pkg;

    localparam int FMEAS_W = 24;
    localparam int CNT_W   = 32;

    typedef enum logic [2:0] {
        IDLE,
        SWITCH,
        HOLD,
        WAIT_LOCK,
        MEASURE,
        CHECK,
        RUN,
        ERROR
    } state_t;

    typedef logic [1:0] err_t;

    localparam err_t ERR_NONE      = 2'd0;
    localparam err_t ERR_LOCK_TO   = 2'd1;
    localparam err_t ERR_FREQ      = 2'd2;
    localparam err_t ERR_LOCK_LOST = 2'd3;

endpackage

// File: rtl/clkwiz_seq_if.sv
// Command, clock-wizard control and status signals between the sequencer and its environment.
interface clkwiz_seq_if;
    import clkwiz_pkg::*;

    logic               cmd_valid;
    logic               cmd_src;
    logic               cmd_ready;
    logic               clk_reset;
    logic               sys_reset;
    logic               clkin_src_sel;
    logic               clk_locked;
    logic               fmeas_enable;
    logic [FMEAS_W-1:0] fmeas_count;
    logic               busy;
    logic               running;
    err_t               err_code;
    logic [FMEAS_W-1:0] meas_value;

    modport master (
        input  cmd_valid, cmd_src, clk_locked, fmeas_count,
        output cmd_ready, clk_reset, sys_reset, clkin_src_sel, fmeas_enable,
               busy, running, err_code, meas_value
    );

    modport slave (
        output cmd_valid, cmd_src, clk_locked, fmeas_count,
        input  cmd_ready, clk_reset, sys_reset, clkin_src_sel, fmeas_enable,
               busy, running, err_code, meas_value
    );

endinterface

// File: rtl/clkwiz_seq.sv
// Bring-up and clock-switch sequencer: switches the MMCM input, waits for lock,
// checks the measured frequency and then releases system reset, watching for lock loss.
module clkwiz_seq
    import clkwiz_pkg::*;
#(
    parameter int unsigned        RST_CYCLES   = 16,
    parameter int unsigned        LOCK_TIMEOUT = 1000000,
    parameter int unsigned        MEAS_CYCLES  = 200000,
    parameter logic [FMEAS_W-1:0] FMIN         = 24'd0,
    parameter logic [FMEAS_W-1:0] FMAX         = 24'hFFFFFF
) (
    input logic          pl_clk0,
    input logic          pl_reset_n,
    clkwiz_seq_if.master bus
);

    localparam logic [CNT_W-1:0] RST_LOAD  = CNT_W'(RST_CYCLES - 32'd1);
    localparam logic [CNT_W-1:0] LOCK_LOAD = CNT_W'(LOCK_TIMEOUT - 32'd1);
    localparam logic [CNT_W-1:0] MEAS_LOAD = CNT_W'(MEAS_CYCLES - 32'd1);

    state_t             r_state, w_state;
    logic [CNT_W-1:0]   r_cnt, w_cnt;
    logic               r_src, w_src;
    logic               r_clk_reset, w_clk_reset;
    logic               r_sys_reset, w_sys_reset;
    logic               r_clkin_sel, w_clkin_sel;
    logic               r_fmeas_en, w_fmeas_en;
    logic               r_cmd_ready, w_cmd_ready;
    logic               r_busy;
    logic               r_running, w_running;
    err_t               r_err, w_err;
    logic [FMEAS_W-1:0] r_meas, w_meas;
    logic               w_accept;
    logic               w_cnt_zero;

    function automatic logic in_window(input logic [FMEAS_W-1:0] v,
                                       input logic [FMEAS_W-1:0] lo,
                                       input logic [FMEAS_W-1:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

    assign w_accept    = bus.cmd_valid && r_cmd_ready;
    assign w_cnt_zero  = (r_cnt == '0);
    assign w_cmd_ready = (w_state == IDLE) || (w_state == RUN) || (w_state == ERROR);

    always_ff @(posedge pl_clk0 or negedge pl_reset_n) begin
        if (!pl_reset_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_src       <= 1'b0;
            r_clk_reset <= 1'b1;
            r_sys_reset <= 1'b1;
            r_clkin_sel <= 1'b0;
            r_fmeas_en  <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_running   <= 1'b0;
            r_err       <= ERR_NONE;
            r_meas      <= '0;
        end else begin
            r_state     <= w_state;
            r_cnt       <= w_cnt;
            r_src       <= w_src;
            r_clk_reset <= w_clk_reset;
            r_sys_reset <= w_sys_reset;
            r_clkin_sel <= w_clkin_sel;
            r_fmeas_en  <= w_fmeas_en;
            r_cmd_ready <= w_cmd_ready;
            r_busy      <= !w_cmd_ready;
            r_running   <= w_running;
            r_err       <= w_err;
            r_meas      <= w_meas;
        end
    end

    always_comb begin
        w_state     = r_state;
        w_cnt       = r_cnt;
        w_src       = r_src;
        w_clk_reset = r_clk_reset;
        w_sys_reset = r_sys_reset;
        w_clkin_sel = r_clkin_sel;
        w_fmeas_en  = r_fmeas_en;
        w_running   = r_running;
        w_err       = r_err;
        w_meas      = r_meas;

        unique case (r_state)
            IDLE, RUN, ERROR: begin
                // A new command takes priority over a lock loss seen on the same cycle.
                if (w_accept) begin
                    w_state     = SWITCH;
                    w_src       = bus.cmd_src;
                    w_clk_reset = 1'b1;
                    w_sys_reset = 1'b1;
                    w_fmeas_en  = 1'b0;
                    w_running   = 1'b0;
                    w_err       = ERR_NONE;
                end else if ((r_state == RUN) && !bus.clk_locked) begin
                    w_state     = ERROR;
                    w_sys_reset = 1'b1;
                    w_running   = 1'b0;
                    w_err       = ERR_LOCK_LOST;
                end
            end
            SWITCH: begin
                w_clkin_sel = r_src;
                w_cnt       = RST_LOAD;
                w_state     = HOLD;
            end
            HOLD: begin
                // Lock is deliberately not looked at while the MMCM is held in reset.
                if (w_cnt_zero) begin
                    w_clk_reset = 1'b0;
                    w_cnt       = LOCK_LOAD;
                    w_state     = WAIT_LOCK;
                end else begin
                    w_cnt = r_cnt - 1'b1;
                end
            end
            WAIT_LOCK: begin
                if (bus.clk_locked) begin
                    w_fmeas_en = 1'b1;
                    w_cnt      = MEAS_LOAD;
                    w_state    = MEASURE;
                end else if (w_cnt_zero) begin
                    w_err       = ERR_LOCK_TO;
                    w_sys_reset = 1'b1;
                    w_clk_reset = 1'b0;
                    w_state     = ERROR;
                end else begin
                    w_cnt = r_cnt - 1'b1;
                end
            end
            MEASURE: begin
                if (!bus.clk_locked) begin
                    w_fmeas_en  = 1'b0;
                    w_err       = ERR_LOCK_LOST;
                    w_sys_reset = 1'b1;
                    w_clk_reset = 1'b0;
                    w_state     = ERROR;
                end else if (w_cnt_zero) begin
                    w_meas     = bus.fmeas_count;
                    w_fmeas_en = 1'b0;
                    w_state    = CHECK;
                end else begin
                    w_cnt = r_cnt - 1'b1;
                end
            end
            CHECK: begin
                if (in_window(r_meas, FMIN, FMAX)) begin
                    w_sys_reset = 1'b0;
                    w_running   = 1'b1;
                    w_state     = RUN;
                end else begin
                    w_err       = ERR_FREQ;
                    w_sys_reset = 1'b1;
                    w_clk_reset = 1'b0;
                    w_state     = ERROR;
                end
            end
            default: w_state = IDLE;
        endcase
    end

    assign bus.cmd_ready     = r_cmd_ready;
    assign bus.clk_reset     = r_clk_reset;
    assign bus.sys_reset     = r_sys_reset;
    assign bus.clkin_src_sel = r_clkin_sel;
    assign bus.fmeas_enable  = r_fmeas_en;
    assign bus.busy          = r_busy;
    assign bus.running       = r_running;
    assign bus.err_code      = r_err;
    assign bus.meas_value    = r_meas;

endmodule

// File: tb/tb_clkwiz_seq.sv
// Scoreboard bench for clkwiz_seq: each sequence pushes its expected outcome, a monitor
// pops and compares whenever the sequencer settles (busy falls or running drops).
module tb_clkwiz_seq;
    import clkwiz_pkg::*;

    typedef struct {
        logic [1:0]  err;
        logic        run;
        logic        sys;
        logic        clkr;
        logic        sel;
        logic        rdy;
        logic [23:0] meas;
        int          rc;
        int          fc;
        int          wc;
        int          selr;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_err;
    int   n_events;
    exp_t sb[$];

    clkwiz_seq_if bus();

    clkwiz_seq #(
        .RST_CYCLES  (4),
        .LOCK_TIMEOUT(10),
        .MEAS_CYCLES (8),
        .FMIN        (24'd100),
        .FMAX        (24'd200)
    ) dut (
        .pl_clk0   (clk),
        .pl_reset_n(rst_n),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (event %0d): got %0d, expected %0d", name, n_events, act, exp);
        end
    endtask

    // Monitor: pulse-width bookkeeping per sequence plus scoreboard comparison.
    initial begin : monitor
        logic prev_busy, prev_run;
        int   rc, fc, wc, selr;
        exp_t e;
        prev_busy = 1'b0; prev_run = 1'b0;
        rc = 0; fc = 0; wc = 0; selr = 0;
        forever begin
            @(negedge clk);
            if (bus.busy && !prev_busy) begin
                rc = 0; fc = 0; wc = 0;
                chk("accept_err_clear", 32'(bus.err_code), 0);
                chk("accept_clk_reset", 32'(bus.clk_reset), 1);
                chk("accept_sys_reset", 32'(bus.sys_reset), 1);
            end
            if (bus.busy) begin
                if (bus.clk_reset) begin
                    rc++;
                    selr = int'(bus.clkin_src_sel);
                end
                if (bus.fmeas_enable) fc++;
                if (!bus.clk_reset && !bus.fmeas_enable) wc++;
            end
            if ((prev_busy && !bus.busy) || (prev_run && !bus.running && !bus.busy)) begin
                if (sb.size() == 0) begin
                    n_checks++; n_err++;
                    $display("FAIL unexpected_event: got event %0d, expected none", n_events);
                end else begin
                    e = sb.pop_front();
                    chk("err_code",      32'(bus.err_code),      32'(e.err));
                    chk("running",       32'(bus.running),       32'(e.run));
                    chk("sys_reset",     32'(bus.sys_reset),     32'(e.sys));
                    chk("clk_reset",     32'(bus.clk_reset),     32'(e.clkr));
                    chk("clkin_src_sel", 32'(bus.clkin_src_sel), 32'(e.sel));
                    chk("cmd_ready",     32'(bus.cmd_ready),     32'(e.rdy));
                    chk("meas_value",    32'(bus.meas_value),    32'(e.meas));
                    if (e.rc >= 0)   chk("clk_reset_cycles", rc, e.rc);
                    if (e.fc >= 0)   chk("fmeas_cycles",     fc, e.fc);
                    if (e.wc >= 0)   chk("wait_cycles",      wc, e.wc);
                    if (e.selr >= 0) chk("sel_during_reset", selr, e.selr);
                end
                n_events++;
            end
            prev_busy = bus.busy;
            prev_run  = bus.running;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_event(input int base, input string name);
        int n;
        n = 0;
        while (n_events == base && n < 200) begin
            cyc();
            n++;
        end
        if (n_events == base) begin
            n_checks++; n_err++;
            $display("FAIL %s_timeout: got no event after %0d cycles, expected one", name, n);
            if (sb.size() > 0) void'(sb.pop_front());
        end
    endtask

    // d < 0: lock held high throughout; 0..98: lock raised d cycles after clk_reset falls;
    // 99: lock never raised.  drop >= 0: lock pulsed low once, drop cycles after raising.
    task automatic run_vec(input string name, input logic src, input logic [23:0] cnt,
                           input int d, input int drop, input logic [1:0] err,
                           input logic run, input logic [23:0] meas,
                           input int fc, input int wc);
        exp_t e;
        int   base, n;
        e.err = err; e.run = run; e.sys = !run; e.clkr = 1'b0; e.sel = src; e.rdy = 1'b1;
        e.meas = meas; e.rc = 5; e.fc = fc; e.wc = wc; e.selr = int'(src);
        base = n_events;
        sb.push_back(e);
        bus.fmeas_count = cnt;
        bus.cmd_src     = src;
        bus.cmd_valid   = 1'b1;
        cyc();
        bus.cmd_valid   = 1'b0;
        bus.cmd_src     = ~src;
        bus.clk_locked  = (d < 0);
        n = 0;
        while (bus.clk_reset !== 1'b0 && n < 50) begin
            cyc();
            n++;
        end
        if (d >= 0 && d < 99) begin
            repeat (d) cyc();
            bus.clk_locked = 1'b1;
            if (drop >= 0) begin
                repeat (drop) cyc();
                bus.clk_locked = 1'b0;
                cyc();
                bus.clk_locked = 1'b1;
            end
        end
        wait_event(base, name);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got no completion, expected bench to finish");
        $fatal(1);
    end

    initial begin : stim
        exp_t e;
        int   base, n;
        n_checks = 0; n_err = 0; n_events = 0;
        rst_n = 1'b0;
        bus.cmd_valid = 1'b0; bus.cmd_src = 1'b0;
        bus.clk_locked = 1'b0; bus.fmeas_count = '0;
        repeat (3) @(negedge clk);
        chk("rst_clk_reset", 32'(bus.clk_reset), 1);
        chk("rst_sys_reset", 32'(bus.sys_reset), 1);
        chk("rst_sel",       32'(bus.clkin_src_sel), 0);
        chk("rst_fmeas_en",  32'(bus.fmeas_enable), 0);
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 1);
        chk("rst_busy",      32'(bus.busy), 0);
        chk("rst_running",   32'(bus.running), 0);
        chk("rst_err",       32'(bus.err_code), 0);
        chk("rst_meas",      32'(bus.meas_value), 0);
        cyc();
        rst_n = 1'b1;
        cyc();

        run_vec("nominal",   1'b1, 24'd150, 3, -1, 2'd0, 1'b1, 24'd150, 8, 5);

        // Lock lost for one cycle while running.
        e.err = ERR_LOCK_LOST; e.run = 1'b0; e.sys = 1'b1; e.clkr = 1'b0; e.sel = 1'b1;
        e.rdy = 1'b1; e.meas = 24'd150; e.rc = -1; e.fc = -1; e.wc = -1; e.selr = -1;
        base = n_events;
        sb.push_back(e);
        bus.clk_locked = 1'b0;
        cyc();
        bus.clk_locked = 1'b1;
        chk("lost_sys_reset_next", 32'(bus.sys_reset), 1);
        chk("lost_running_next",   32'(bus.running), 0);
        chk("lost_err_next",       32'(bus.err_code), 3);
        wait_event(base, "lock_lost_run");

        run_vec("rerun_src0",   1'b0, 24'd150, -1, -1, 2'd0, 1'b1, 24'd150, 8, 2);
        run_vec("freq_high",    1'b1, 24'd250,  0, -1, 2'd2, 1'b0, 24'd250, 8, 2);
        run_vec("lock_timeout", 1'b0, 24'd150, 99, -1, 2'd1, 1'b0, 24'd250, 0, 10);
        run_vec("lock_at_expiry", 1'b1, 24'd200, 9, -1, 2'd0, 1'b1, 24'd200, 8, 11);
        run_vec("fmin_edge",    1'b1, 24'd100,  1, -1, 2'd0, 1'b1, 24'd100, 8, 3);
        run_vec("below_fmin",   1'b0, 24'd99,  -1, -1, 2'd2, 1'b0, 24'd99,  8, 2);
        run_vec("above_fmax",   1'b1, 24'd201, -1, -1, 2'd2, 1'b0, 24'd201, 8, 2);
        run_vec("lost_in_meas", 1'b0, 24'd150,  0,  2, 2'd3, 1'b0, 24'd201, 2, 1);

        // Async reset in the middle of MEASURE, after an ignored command while busy.
        e.err = ERR_NONE; e.run = 1'b0; e.sys = 1'b1; e.clkr = 1'b1; e.sel = 1'b0;
        e.rdy = 1'b1; e.meas = 24'd0; e.rc = -1; e.fc = -1; e.wc = -1; e.selr = -1;
        base = n_events;
        sb.push_back(e);
        bus.fmeas_count = 24'd150;
        bus.cmd_src = 1'b1; bus.cmd_valid = 1'b1;
        cyc();
        bus.cmd_valid = 1'b0; bus.clk_locked = 1'b1;
        n = 0;
        while (bus.fmeas_enable !== 1'b1 && n < 50) begin
            cyc();
            n++;
        end
        chk("meas_started", 32'(bus.fmeas_enable), 1);
        bus.cmd_src = 1'b0; bus.cmd_valid = 1'b1;
        chk("busy_cmd_ready", 32'(bus.cmd_ready), 0);
        cyc();
        bus.cmd_valid = 1'b0;
        chk("busy_cmd_ignored_fmeas", 32'(bus.fmeas_enable), 1);
        chk("busy_cmd_ignored_sel",   32'(bus.clkin_src_sel), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_clk_reset", 32'(bus.clk_reset), 1);
        chk("arst_fmeas_en",  32'(bus.fmeas_enable), 0);
        chk("arst_sel",       32'(bus.clkin_src_sel), 0);
        chk("arst_busy",      32'(bus.busy), 0);
        chk("arst_meas",      32'(bus.meas_value), 0);
        #1 rst_n = 1'b1;
        wait_event(base, "async_reset");

        repeat (3) cyc();
        chk("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
